// File: rtl/rnn_host_master_if.sv
// rnn_host_master_if
// Groups the three channels of the rnn host master:
//   cmd_*  command stream in (valid/ready; op, slave address, 32-bit payload)
//   rsp_*  response stream out (valid/ready; error flag, signed 16-bit result)
//   avm_*  Avalon-MM initiator port towards the rnn accelerator slave
// Modport master is the view of rnn_host_master itself. Modport slave is the
// view of whatever surrounds it: command source, response sink and Avalon slave.
interface rnn_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [15:0] rsp_data;

  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_err, rsp_data,
    input  rsp_ready,
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_err, rsp_data,
    output rsp_ready,
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/rnn_host_master.sv
// rnn_host_master
// Avalon-MM initiator that runs the rnn accelerator on behalf of a command
// stream. Each command is a parameter write (op 0), a recurrent step (op 1:
// start, then poll the load status until done) or a finish (op 2: dense pass,
// poll the valid status, read the result). Op 3 is reserved and answered with
// an error. Every accepted command produces exactly one response.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active high
//   busy  high in every state except IDLE
//   bus   rnn_host_master_if.master: cmd_*, rsp_*, avm_* channels
// Parameters:
//   POLL_GAP  idle cycles between a transfer and the following status poll
//   TO_BITS   poll counter width; a command times out after 2**TO_BITS-1
//             polls that did not return the done bit (TO_BITS >= 1)
module rnn_host_master #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TO_BITS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  rnn_host_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, WR_PARAM, WR_START, POLL_LOAD, WR_DENSE,
    POLL_VALID, RD_RESULT, GAP, RSP
  } state_t;

  localparam logic [2:0] ADDR_START  = 3'd0;  // write: kick a recurrent step
  localparam logic [2:0] ADDR_VALID  = 3'd0;  // read: result-valid status
  localparam logic [2:0] ADDR_LOAD   = 3'd1;  // read: step-done status
  localparam logic [2:0] ADDR_DENSE  = 3'd7;  // write: dense pass / read: result

  // Counter value seen while the final permitted poll completes.
  localparam logic [TO_BITS-1:0] POLL_LAST = TO_BITS'(2**TO_BITS - 2);

  localparam int unsigned        GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

  state_t              state_q, state_d;
  state_t              resume_q, resume_d;   // where GAP goes when it expires
  logic [2:0]          cmd_addr_q;
  logic [31:0]         cmd_data_q;
  logic [TO_BITS-1:0]  poll_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic                rsp_err_q;
  logic [15:0]         rsp_data_q;

  logic                accept;
  logic                poll_fire;
  logic                timeout;
  logic                capture;
  logic                rsp_take;
  logic [2:0]          avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [31:0]         avm_writedata;
  logic                unused_readdata;

  // With POLL_GAP=0 the gap is skipped and the poll re-issues the next cycle.
  function automatic state_t gap_to(state_t nxt);
    return (POLL_GAP == 0) ? nxt : GAP;
  endfunction

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // NOTE: every signal driven in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    resume_d      = resume_q;
    avm_address   = '0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    poll_fire     = 1'b0;
    timeout       = 1'b0;
    capture       = 1'b0;
    rsp_take      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            2'd0:    state_d = WR_PARAM;
            2'd1:    state_d = WR_START;
            2'd2:    state_d = WR_DENSE;
            default: state_d = RSP;
          endcase
        end
      end

      WR_PARAM: begin
        avm_address   = cmd_addr_q;
        avm_write     = 1'b1;
        avm_writedata = cmd_data_q;
        if (!bus.avm_waitrequest) state_d = RSP;
      end

      WR_START: begin
        avm_address = ADDR_START;
        avm_write   = 1'b1;
        if (!bus.avm_waitrequest) begin
          resume_d = POLL_LOAD;
          state_d  = gap_to(POLL_LOAD);
        end
      end

      WR_DENSE: begin
        avm_address = ADDR_DENSE;
        avm_write   = 1'b1;
        if (!bus.avm_waitrequest) begin
          resume_d = POLL_VALID;
          state_d  = gap_to(POLL_VALID);
        end
      end

      POLL_LOAD, POLL_VALID: begin
        avm_address = (state_q == POLL_LOAD) ? ADDR_LOAD : ADDR_VALID;
        avm_read    = 1'b1;
        if (!bus.avm_waitrequest) begin
          poll_fire = 1'b1;
          if (bus.avm_readdata[0]) begin
            state_d = (state_q == POLL_LOAD) ? RSP : RD_RESULT;
          end else if (poll_cnt_q == POLL_LAST) begin
            // Timed out: a FINISH never reaches RD_RESULT.
            timeout = 1'b1;
            state_d = RSP;
          end else begin
            resume_d = state_q;
            state_d  = gap_to(state_q);
          end
        end
      end

      RD_RESULT: begin
        avm_address = ADDR_DENSE;
        avm_read    = 1'b1;
        if (!bus.avm_waitrequest) begin
          capture = 1'b1;
          state_d = RSP;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = resume_q;
      end

      RSP: begin
        if (bus.rsp_ready) begin
          rsp_take = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        cmd_addr_q <= bus.cmd_addr;
        cmd_data_q <= bus.cmd_data;
        poll_cnt_q <= '0;
        rsp_err_q  <= (bus.cmd_op == 2'd3);
        rsp_data_q <= '0;
      end
      if (poll_fire) poll_cnt_q <= poll_cnt_q + 1'b1;
      if (timeout)   rsp_err_q  <= 1'b1;
      if (capture)   rsp_data_q <= bus.avm_readdata[15:0];
      if (rsp_take) begin
        rsp_err_q  <= 1'b0;
        rsp_data_q <= '0;
      end
      gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 1'b1 : '0;
    end
  end

  // Bus requests decode straight from the state register, so an asynchronous
  // reset drops avm_read/avm_write immediately, and they stay stable while
  // the slave stalls because the state does not move.
  assign bus.avm_address   = avm_address;
  assign bus.avm_read      = avm_read;
  assign bus.avm_write     = avm_write;
  assign bus.avm_writedata = avm_writedata;

  // Gated with rst so no command is offered while the block is held in reset.
  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != IDLE);

  assign unused_readdata = ^bus.avm_readdata[31:16];

endmodule

// File: tb/tb_rnn_host_master.sv
module tb_rnn_host_master;

  localparam int unsigned POLL_GAP  = 4;
  localparam int unsigned TO_BITS   = 4;
  localparam int          MAX_POLLS = 2**TO_BITS - 1;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    int          idle;
    int          cycles;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  rnn_host_master_if bus ();

  rnn_host_master #(.POLL_GAP(POLL_GAP), .TO_BITS(TO_BITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model controls (written by the directed sequence, read by the slave).
  bit          rand_stall = 1'b0;
  int          stall_req  = 0;
  int          zeros_tgt  = 0;
  int          base_polls = 0;
  logic [15:0] result_val = '0;
  // Written by the slave model.
  int          poll_total = 0;
  xfer_t       xq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t mk(bit wr, logic [2:0] addr, logic [31:0] data, int idle);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.data = data; x.idle = idle; x.cycles = 0;
    return x;
  endfunction

  // Avalon slave + bus monitor, evaluated mid-cycle on the falling edge.
  initial begin
    bit          in_xfer = 1'b0;
    bit          prev_stalled = 1'b0;
    int          stall_left = 0;
    int          idle_run = 0;
    xfer_t       cur;
    logic [37:0] prev_sig = '0;
    logic [31:0] junk;
    forever begin
      @(negedge clk);
      junk = $urandom;
      bus.avm_readdata = junk;
      if (rst) begin
        in_xfer = 1'b0; prev_stalled = 1'b0; idle_run = 0;
        bus.avm_waitrequest = 1'b0;
        continue;
      end
      check("one_hot_req", {62'd0, bus.avm_read, bus.avm_write} == 64'd3, 64'd0);
      if (prev_stalled)
        check("stall_stable", {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata}, prev_sig);
      if (!(bus.avm_read || bus.avm_write)) begin
        idle_run++;
        bus.avm_waitrequest = 1'b0;
        prev_stalled = 1'b0;
      end else begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          cur = mk(bus.avm_write, bus.avm_address, bus.avm_write ? bus.avm_writedata : 32'd0, idle_run);
          idle_run = 0;
          stall_left = rand_stall ? $urandom_range(0, 2) : stall_req;
        end
        cur.cycles++;
        if (stall_left > 0) begin
          stall_left--;
          bus.avm_waitrequest = 1'b1;
          prev_stalled = 1'b1;
          prev_sig = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
        end else begin
          bus.avm_waitrequest = 1'b0;
          prev_stalled = 1'b0;
          if (bus.avm_read) begin
            if (bus.avm_address == 3'd7) begin
              bus.avm_readdata = {junk[31:16], result_val};
            end else begin
              bus.avm_readdata = {junk[31:1], ((poll_total - base_polls) >= zeros_tgt) ? 1'b1 : 1'b0};
              poll_total++;
            end
          end
          xq.push_back(cur);
          in_xfer = 1'b0;
        end
      end
    end
  end

  // One command through the DUT, checked against the expected bus transcript
  // and response derived from the command rules.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [31:0] data,
                         input int zeros, input logic [15:0] result, input int hold, input string tag);
    xfer_t exp_q[$];
    bit          ok;
    int          np;
    int          lat;
    logic        exp_err;
    logic [15:0] exp_data;

    ok = (zeros + 1) <= MAX_POLLS;
    np = ok ? zeros + 1 : MAX_POLLS;
    exp_err = 1'b0;
    exp_data = '0;
    case (op)
      2'd0: exp_q.push_back(mk(1'b1, addr, data, 0));
      2'd1: begin
        exp_q.push_back(mk(1'b1, 3'd0, 32'd0, 0));
        repeat (np) exp_q.push_back(mk(1'b0, 3'd1, 32'd0, POLL_GAP));
        exp_err = !ok;
      end
      2'd2: begin
        exp_q.push_back(mk(1'b1, 3'd7, 32'd0, 0));
        repeat (np) exp_q.push_back(mk(1'b0, 3'd0, 32'd0, POLL_GAP));
        if (ok) exp_q.push_back(mk(1'b0, 3'd7, 32'd0, 0));
        exp_err  = !ok;
        exp_data = ok ? result : 16'd0;
      end
      default: exp_err = 1'b1;
    endcase

    xq.delete();
    zeros_tgt  = zeros;
    base_polls = poll_total;
    result_val = result;

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_addr  = 3'($urandom);
    bus.cmd_data  = $urandom;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_not_ready"}, bus.cmd_ready, 0);

    lat = 0;
    while (!bus.rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_rsp_seen"}, bus.rsp_valid, 1);
    if (op == 2'd3) check({tag, "_rsp_latency"}, lat, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, exp_err);
    check({tag, "_rsp_data"}, bus.rsp_data, exp_data);

    repeat (hold) @(negedge clk);
    check({tag, "_rsp_held"}, {bus.rsp_valid, bus.cmd_ready, busy, bus.rsp_err, bus.rsp_data},
          {1'b1, 1'b0, 1'b1, exp_err, exp_data});

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_after_rsp"}, {bus.rsp_valid, busy, bus.rsp_err, bus.rsp_data, bus.cmd_ready},
          {1'b0, 1'b0, 1'b0, 16'd0, 1'b1});

    check({tag, "_xfer_count"}, xq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < xq.size(); i++) begin
      check($sformatf("%s_xfer%0d", tag, i), {xq[i].wr, xq[i].addr, xq[i].data},
            {exp_q[i].wr, exp_q[i].addr, exp_q[i].data});
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), xq[i].idle, exp_q[i].idle);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  zeros;
    bit  found;
    logic [1:0] op;

    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_addr = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    bus.avm_readdata = '0;
    bus.avm_waitrequest = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, busy,
                            bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata},
          '0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_release_ready", bus.cmd_ready, 1);

    // 1: write with three stall cycles.
    stall_req = 3;
    run_cmd(2'd0, 3'd2, 32'h0103_0100, 0, 16'd0, 1, "t1_write");
    check("t1_hold_cycles", (xq.size() > 0) ? xq[0].cycles : -1, 4);
    stall_req = 0;

    // 2: step done on 3rd poll.
    run_cmd(2'd1, 3'd5, 32'hDEAD_BEEF, 2, 16'd0, 0, "t2_step");
    // 3: finish done on 2nd poll, negative result.
    run_cmd(2'd2, 3'd0, 32'd0, 1, 16'hFF80, 2, "t3_finish");
    // 4: step stuck at 0 -> timeout after MAX_POLLS polls.
    run_cmd(2'd1, 3'd0, 32'd0, 100, 16'd0, 1, "t4_step_to");
    // Boundaries: done on exactly the last permitted poll, and one poll too late.
    run_cmd(2'd1, 3'd0, 32'd0, MAX_POLLS - 1, 16'd0, 0, "step_last_ok");
    run_cmd(2'd2, 3'd0, 32'd0, MAX_POLLS, 16'h1234, 0, "finish_to");
    run_cmd(2'd2, 3'd0, 32'd0, MAX_POLLS - 1, 16'h7FFF, 0, "finish_last_ok");
    // 5: reserved op, response held for 5 cycles.
    run_cmd(2'd3, 3'd4, 32'h5555_AAAA, 0, 16'd0, 5, "t5_reserved");
    // Writes to control addresses are forwarded unchanged.
    run_cmd(2'd0, 3'd0, 32'h8000_0001, 0, 16'd0, 0, "write_addr0");
    run_cmd(2'd0, 3'd7, 32'hFFFF_FFFF, 0, 16'd0, 0, "write_addr7");

    // Randomized commands with random slave stalls.
    rand_stall = 1'b1;
    for (int n = 0; n < 14; n++) begin
      op = 2'($urandom_range(0, 3));
      zeros = ($urandom_range(0, 4) == 0) ? $urandom_range(MAX_POLLS - 1, MAX_POLLS + 1)
                                          : $urandom_range(0, 3);
      run_cmd(op, 3'($urandom_range(1, 6)), $urandom, zeros, 16'($urandom),
              $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end
    rand_stall = 1'b0;

    // 6: reset while a POLL_VALID read is on the bus.
    zeros_tgt  = 1000;
    base_polls = poll_total;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.avm_read && bus.avm_address == 3'd0) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_poll", found, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_reset_drop", {bus.avm_read, bus.avm_write, busy, bus.rsp_valid, bus.cmd_ready}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ready_after", {bus.cmd_ready, busy}, {1'b1, 1'b0});
    run_cmd(2'd0, 3'd3, 32'h0A0B_0C0D, 0, 16'd0, 1, "t6_write");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
